// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed LATENCY cycles from accept to rsp_valid.
// req_ready only in IDLE; stall holds the pipeline from request until the completion cycle.
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  counter;
  logic        capWe;
  logic [31:0] capAddr;
  logic [3:0]  capBe;
  logic [31:0] capWdata;

  logic        accWe;
  logic [31:0] accAddr;
  logic [3:0]  accBe;
  logic [31:0] accWdata;
  logic        accErr;
  logic        doAccess;
  logic [ADDR_BITS-1:0] wordIdx;
  logic [31:0] oldWord;
  logic [31:0] newWord;

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  // With LATENCY==1 the access happens on the accept edge, so use the live request.
  always_comb begin
    accWe    = capWe;
    accAddr  = capAddr;
    accBe    = capBe;
    accWdata = capWdata;
    if (state == IDLE) begin
      accWe    = req_we;
      accAddr  = req_addr;
      accBe    = req_be;
      accWdata = req_wdata;
    end
  end

  assign wordIdx  = accAddr[ADDR_BITS+1:2];
  assign accErr   = (accAddr[1:0] != 2'b00) || (accAddr[31:ADDR_BITS+2] != '0);
  assign oldWord  = mem[wordIdx];
  assign doAccess = rst && (((state == IDLE) && req_valid && (LATENCY == 1)) ||
                            ((state == BUSY) && (counter == 4'd1)));

  always_comb begin
    newWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (accBe[i]) newWord[8*i +: 8] = accWdata[8*i +: 8];
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign stall     = rst && (((state == IDLE) && req_valid) || (state == BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= 4'd0;
      capWe     <= 1'b0;
      capAddr   <= 32'd0;
      capBe     <= 4'd0;
      capWdata  <= 32'd0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            capWe    <= req_we;
            capAddr  <= req_addr;
            capBe    <= req_be;
            capWdata <= req_wdata;
            counter  <= CNT_INIT;
            state    <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (doAccess) begin
        rsp_err   <= accErr;
        rsp_rdata <= accErr ? 32'd0 : (accWe ? newWord : oldWord);
      end
    end
  end

  // RAM contents survive reset; doAccess is already gated by rst.
  always_ff @(posedge clk) begin
    if (doAccess && accWe && !accErr) mem[wordIdx] <= newWord;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 at LATENCY=3, instance 1 at LATENCY=1.
// Directed requests push expected responses; a negedge monitor pops and compares.
module tb_dmem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        reqValid [2];
  logic        reqWe    [2];
  logic [31:0] reqAddr  [2];
  logic [3:0]  reqBe    [2];
  logic [31:0] reqWdata [2];
  logic        reqReady [2];
  logic        rspValid [2];
  logic        rspErr   [2];
  logic [31:0] rspRdata [2];
  logic        stall    [2];

  rsp_t expQ0[$];
  rsp_t expQ1[$];
  rsp_t e0, e1;
  int   checks;
  int   failures;
  int   cyc;
  int   lastDone [2];
  int   latOf    [2];

  dmem_responder #(.ADDR_BITS(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_we(reqWe[0]), .req_addr(reqAddr[0]),
    .req_be(reqBe[0]), .req_wdata(reqWdata[0]), .req_ready(reqReady[0]),
    .rsp_valid(rspValid[0]), .rsp_err(rspErr[0]), .rsp_rdata(rspRdata[0]),
    .stall(stall[0])
  );

  dmem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_we(reqWe[1]), .req_addr(reqAddr[1]),
    .req_be(reqBe[1]), .req_wdata(reqWdata[1]), .req_ready(reqReady[1]),
    .rsp_valid(rspValid[1]), .rsp_err(rspErr[1]), .rsp_rdata(rspRdata[1]),
    .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rspValid[0] === 1'b1) begin
      if (expQ0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        e0 = expQ0.pop_front();
        check("rsp0_err", {31'd0, rspErr[0]}, {31'd0, e0.err});
        check("rsp0_rdata", rspRdata[0], e0.rdata);
      end
    end
    if (rspValid[1] === 1'b1) begin
      if (expQ1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = expQ1.pop_front();
        check("rsp1_err", {31'd0, rspErr[1]}, {31'd0, e1.err});
        check("rsp1_rdata", rspRdata[1], e1.rdata);
      end
    end
  end

  task automatic doReq(input int d, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic expErr, input logic [31:0] expRdata);
    int n;
    rsp_t r;
    r.err   = expErr;
    r.rdata = expRdata;
    if (d == 0) expQ0.push_back(r);
    else        expQ1.push_back(r);
    @(negedge clk);
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqBe[d]    = be;
    reqWdata[d] = wdata;
    #1;
    check("stall_on_request", {31'd0, stall[d]}, 32'd1);
    check("ready_in_idle", {31'd0, reqReady[d]}, 32'd1);
    @(posedge clk);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (rspValid[d] === 1'b1) break;
      check("stall_busy", {31'd0, stall[d]}, 32'd1);
      check("ready_busy", {31'd0, reqReady[d]}, 32'd0);
      if (n > 40) begin
        check("rsp_timeout", 32'd1, 32'd0);
        break;
      end
    end
    check("latency", n, latOf[d]);
    check("stall_done", {31'd0, stall[d]}, 32'd0);
    check("ready_done", {31'd0, reqReady[d]}, 32'd0);
    lastDone[d] = cyc;
    reqValid[d] = 1'b0;
  endtask

  initial begin
    int t;
    int pulses;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    latOf[0] = 3;
    latOf[1] = 1;
    for (int d = 0; d < 2; d++) begin
      reqValid[d] = 1'b0;
      reqWe[d]    = 1'b0;
      reqAddr[d]  = 32'd0;
      reqBe[d]    = 4'd0;
      reqWdata[d] = 32'd0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", {31'd0, reqReady[d]}, 32'd1);
      check("reset_valid", {31'd0, rspValid[d]}, 32'd0);
      check("reset_err", {31'd0, rspErr[d]}, 32'd0);
      check("reset_rdata", rspRdata[d], 32'd0);
      check("reset_stall", {31'd0, stall[d]}, 32'd0);
    end
    rst = 1'b1;

    // Full-word store, read-after-write data, then a load and a hold check.
    doReq(0, 1'b1, 32'h40, 4'b1111, 32'h12345678, 1'b0, 32'h12345678);
    doReq(0, 1'b0, 32'h40, 4'b0000, 32'h0, 1'b0, 32'h12345678);
    @(negedge clk);
    check("rdata_hold", rspRdata[0], 32'h12345678);

    // Partial store merges bytes 0 and 2.
    doReq(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h12BB56DD);
    doReq(0, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, 32'h12BB56DD);

    // Error cases; 0x1000 aliases word 0 if the range check were missing.
    doReq(0, 1'b1, 32'h0, 4'b1111, 32'hCAFEBABE, 1'b0, 32'hCAFEBABE);
    doReq(0, 1'b0, 32'h42, 4'b0000, 32'h0, 1'b1, 32'h0);
    doReq(0, 1'b0, 32'h1000, 4'b0000, 32'h0, 1'b1, 32'h0);
    doReq(0, 1'b1, 32'h1, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0);
    doReq(0, 1'b1, 32'h1000, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0);
    doReq(0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hCAFEBABE);

    // Empty byte mask is an acknowledged no-op.
    doReq(0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h12BB56DD);
    doReq(0, 1'b0, 32'h40, 4'b0000, 32'h0, 1'b0, 32'h12BB56DD);

    // Asynchronous reset while a store is in flight.
    doReq(0, 1'b1, 32'h80, 4'b1111, 32'h0BADF00D, 1'b0, 32'h0BADF00D);
    @(negedge clk);
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b1;
    reqAddr[0]  = 32'h80;
    reqBe[0]    = 4'b1111;
    reqWdata[0] = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    check("busy_before_reset", {31'd0, stall[0]}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, reqReady[0]}, 32'd1);
    check("arst_valid", {31'd0, rspValid[0]}, 32'd0);
    check("arst_stall", {31'd0, stall[0]}, 32'd0);
    check("arst_err", {31'd0, rspErr[0]}, 32'd0);
    check("arst_rdata", rspRdata[0], 32'd0);
    reqValid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (rspValid[0] === 1'b1) pulses++;
    end
    check("no_rsp_after_reset", pulses, 32'd0);
    doReq(0, 1'b0, 32'h80, 4'b0000, 32'h0, 1'b0, 32'h0BADF00D);

    // LATENCY=1 back-to-back loads complete every second cycle.
    doReq(1, 1'b1, 32'h4, 4'b1111, 32'h00000011, 1'b0, 32'h00000011);
    doReq(1, 1'b0, 32'h4, 4'b0000, 32'h0, 1'b0, 32'h00000011);
    t = lastDone[1];
    doReq(1, 1'b0, 32'h4, 4'b0000, 32'h0, 1'b0, 32'h00000011);
    check("b2b_spacing", lastDone[1] - t, 32'd2);

    repeat (5) @(negedge clk);
    check("q0_drained", expQ0.size(), 32'd0);
    check("q1_drained", expQ1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
